// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cpu_pkg
// Description : Shared defaults, owner encoding and helper for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int CPU_ADDR_W     = 32;
  localparam int CPU_DATA_W     = 32;
  localparam int CPU_STARVE_MAX = 3;

  // Which port owns the access currently in flight in the memory pipeline.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // Bits needed to count 0..max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface   : mem_arbiter_if
// Description : Fetch port, data port and memory port bundle for mem_arbiter.
//               slave  = arbiter view, master = requester/memory view.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_W = cpu_pkg::CPU_ADDR_W,
  parameter int DATA_W = cpu_pkg::CPU_DATA_W
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port (fetch/data) arbiter onto a single-port, 1-cycle
//               latency pipelined memory. Data has priority; fetch wins once
//               it has been denied STARVE_MAX consecutive cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = CPU_ADDR_W,
  parameter int DATA_W     = CPU_DATA_W,
  parameter int STARVE_MAX = CPU_STARVE_MAX
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int                    c_starve_w   = cnt_width(STARVE_MAX);
  localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_MAX);
  localparam logic [c_starve_w-1:0] c_starve_one = c_starve_w'(1);

  logic                  w_fetch_wins;
  logic                  w_if_gnt;
  logic                  w_d_gnt;
  logic                  w_if_rvalid;
  logic                  w_d_rvalid;
  logic [ADDR_W-1:0]     w_mem_addr;
  logic [DATA_W-1:0]     w_mem_wdata;

  logic [c_starve_w-1:0] starve_q, starve_d;
  owner_e                owner_q, owner_d;
  logic                  pending_q, pending_d;

  // Same-cycle arbitration; grants are forced low while reset is held.
  always_comb begin
    w_fetch_wins = bus.if_req & (~bus.d_req | (starve_q == c_starve_max));
    w_if_gnt     = ~rst & w_fetch_wins;
    w_d_gnt      = ~rst & bus.d_req & ~w_fetch_wins;
    w_mem_addr   = w_if_gnt ? bus.if_addr : (w_d_gnt ? bus.d_addr : '0);
    w_mem_wdata  = w_d_gnt ? bus.d_wdata : '0;
  end

  // Next-state: starvation count and owner of the access issued this cycle.
  always_comb begin
    starve_d = '0;
    if (bus.if_req && !w_if_gnt) begin
      starve_d = (starve_q == c_starve_max) ? starve_q : starve_q + c_starve_one;
    end
    owner_d = OWN_NONE;
    if (w_if_gnt) begin
      owner_d = OWN_IF;
    end else if (w_d_gnt) begin
      owner_d = OWN_D;
    end
    pending_d = w_if_gnt | w_d_gnt;
  end

  // State registers; reset drops any in-flight response immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q  <= '0;
      owner_q   <= OWN_NONE;
      pending_q <= 1'b0;
    end else begin
      starve_q  <= starve_d;
      owner_q   <= owner_d;
      pending_q <= pending_d;
    end
  end

  // Response routing: read data is steered to the owner, zero otherwise.
  always_comb begin
    w_if_rvalid = pending_q & (owner_q == OWN_IF);
    w_d_rvalid  = pending_q & (owner_q == OWN_D);
  end

  assign bus.if_gnt    = w_if_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.mem_en    = w_if_gnt | w_d_gnt;
  assign bus.mem_we    = w_d_gnt & bus.d_we;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.if_rvalid = w_if_rvalid;
  assign bus.d_rvalid  = w_d_rvalid;
  assign bus.if_rdata  = w_if_rvalid ? bus.mem_rdata : '0;
  assign bus.d_rdata   = w_d_rvalid ? bus.mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with a response
//               scoreboard and a behavioural 1-cycle-latency memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  typedef struct {
    logic [1:0]  port;   // 0 none, 1 fetch, 2 data
    logic        wr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .STARVE_MAX(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents as a pure function of address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : ((a ^ 32'hC0DE0000) + 32'h11);
  endfunction

  // Behavioural memory: read data appears one cycle after the strobe.
  always @(posedge clk) begin
    bus.mem_rdata <= (bus.mem_en && !bus.mem_we) ? mem_f(bus.mem_addr) : 32'h0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, ":ctrl"}, {58'd0, bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid,
                         bus.mem_en, bus.mem_we}, 64'd0);
    chk({tag, ":if_rdata"},  {32'd0, bus.if_rdata},  64'd0);
    chk({tag, ":d_rdata"},   {32'd0, bus.d_rdata},   64'd0);
    chk({tag, ":mem_addr"},  {32'd0, bus.mem_addr},  64'd0);
    chk({tag, ":mem_wdata"}, {32'd0, bus.mem_wdata}, 64'd0);
  endtask

  // One clock cycle: check the response owed from the previous cycle, drive
  // new requests, check the same-cycle grant and memory strobe, queue the
  // expected response. Entered and left at posedge + 1.
  task automatic step(input string tag,
                      input logic ireq, input logic [31:0] iaddr,
                      input logic dreq, input logic dwe,
                      input logic [31:0] daddr, input logic [31:0] dwdata,
                      input logic eig, input logic edg);
    exp_t e;
    exp_t n;
    if (sb.size() == 0) begin
      chk({tag, ":sb_empty"}, 64'd1, 64'd0);
      e = '{port: 2'd0, wr: 1'b0, data: 32'd0};
    end else begin
      e = sb.pop_front();
    end
    chk({tag, ":if_rvalid"}, {63'd0, bus.if_rvalid}, {63'd0, e.port == 2'd1});
    chk({tag, ":d_rvalid"},  {63'd0, bus.d_rvalid},  {63'd0, e.port == 2'd2});
    chk({tag, ":if_rdata"},  {32'd0, bus.if_rdata},  {32'd0, (e.port == 2'd1) ? e.data : 32'd0});
    if (!(e.port == 2'd2 && e.wr)) begin
      chk({tag, ":d_rdata"}, {32'd0, bus.d_rdata}, {32'd0, (e.port == 2'd2) ? e.data : 32'd0});
    end

    bus.if_req  = ireq;
    bus.if_addr = iaddr;
    bus.d_req   = dreq;
    bus.d_we    = dwe;
    bus.d_addr  = daddr;
    bus.d_wdata = dwdata;
    #2;
    chk({tag, ":if_gnt"},    {63'd0, bus.if_gnt}, {63'd0, eig});
    chk({tag, ":d_gnt"},     {63'd0, bus.d_gnt},  {63'd0, edg});
    chk({tag, ":mem_en"},    {63'd0, bus.mem_en}, {63'd0, eig | edg});
    chk({tag, ":mem_we"},    {63'd0, bus.mem_we}, {63'd0, edg & dwe});
    chk({tag, ":mem_addr"},  {32'd0, bus.mem_addr},
        {32'd0, eig ? iaddr : (edg ? daddr : 32'd0)});
    chk({tag, ":mem_wdata"}, {32'd0, bus.mem_wdata}, {32'd0, edg ? dwdata : 32'd0});

    if (eig) begin
      n = '{port: 2'd1, wr: 1'b0, data: mem_f(iaddr)};
    end else if (edg) begin
      n = '{port: 2'd2, wr: dwe, data: dwe ? 32'd0 : mem_f(daddr)};
    end else begin
      n = '{port: 2'd0, wr: 1'b0, data: 32'd0};
    end
    sb.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] ia;
    logic [31:0] da;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0;

    // Reset state, with requests held active to show grants are suppressed.
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h44;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h48; bus.d_wdata = 32'hFFFF0000;
    #1;
    zero_chk("reset");
    @(posedge clk); #1;
    bus.if_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.if_addr = '0; bus.d_addr = '0; bus.d_wdata = '0;
    rst = 1'b0;
    sb.push_back('{port: 2'd0, wr: 1'b0, data: 32'd0});

    // Fetch only.
    step("fetch", 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle("fetch_rsp");

    // Data write, then data read.
    step("dwrite", 1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h12345678, 1'b0, 1'b1);
    idle("dwrite_rsp");
    step("dread", 1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 1'b1);
    idle("dread_rsp");

    // Continuous contention: D, D, D, IF repeated twice.
    ia = 32'h200;
    da = 32'h300;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) begin
        step("contend_d", 1'b1, ia, 1'b1, 1'b0, da, 32'h0, 1'b0, 1'b1);
        da = da + 32'h4;
      end
      step("contend_if", 1'b1, ia, 1'b1, 1'b0, da, 32'h0, 1'b1, 1'b0);
      ia = ia + 32'h4;
    end

    // Starvation count clears when fetch stops requesting.
    step("starve_a", 1'b1, ia, 1'b1, 1'b0, da, 32'h0, 1'b0, 1'b1);
    da = da + 32'h4;
    step("starve_b", 1'b1, ia, 1'b1, 1'b0, da, 32'h0, 1'b0, 1'b1);
    da = da + 32'h4;
    step("starve_drop", 1'b0, 32'h0, 1'b1, 1'b0, da, 32'h0, 1'b0, 1'b1);
    da = da + 32'h4;
    for (int k = 0; k < 3; k++) begin
      step("restarve_d", 1'b1, ia, 1'b1, 1'b0, da, 32'h0, 1'b0, 1'b1);
      da = da + 32'h4;
    end
    step("restarve_if", 1'b1, ia, 1'b1, 1'b0, da, 32'h0, 1'b1, 1'b0);

    // Alternating single requesters, back-to-back with no bubble.
    for (int k = 0; k < 3; k++) begin
      step("alt_if", 1'b1, 32'h500 + 32'(k * 8), 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step("alt_d",  1'b0, 32'h0, 1'b1, 1'b0, 32'h600 + 32'(k * 8), 32'h0, 1'b0, 1'b1);
    end
    step("alt_dw", 1'b0, 32'h0, 1'b1, 1'b1, 32'h700, 32'hA5A5A5A5, 1'b0, 1'b1);
    step("alt_if2", 1'b1, 32'h704, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle("alt_rsp");

    // Reset on the cycle after a grant drops the response.
    step("pre_rst", 1'b1, 32'h180, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    rst = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h184;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h188; bus.d_wdata = 32'h0BADF00D;
    #1;
    zero_chk("mid_rst");
    @(posedge clk); #1;
    zero_chk("held_rst");
    bus.if_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    rst = 1'b0;
    sb.delete();
    sb.push_back('{port: 2'd0, wr: 1'b0, data: 32'd0});
    idle("post_rst");

    // Arbitration resumes normally.
    step("resume", 1'b1, 32'h100, 1'b1, 1'b0, 32'h90, 32'h0, 1'b0, 1'b1);
    step("resume_if", 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle("resume_rsp");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
Parameters (name, default, meaning):
REQ-001 ADDR_W, 32, byte-address width of all address ports.
REQ-002 DATA_W, 32, data width of all data ports.
REQ-003 STARVE_MAX, 3, consecutive denied fetch cycles after which fetch wins priority.

Ports (name, direction, width, meaning):
REQ-004 Timing and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  system clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 if_req  in  1  instruction-fetch read request.
REQ-008 if_addr  in  ADDR_W  fetch address.
REQ-009 if_gnt  out  1  fetch request accepted this cycle.
REQ-010 if_rvalid  out  1  fetch data valid.
REQ-011 if_rdata  out  DATA_W  fetch data.
REQ-012 d_req  in  1  data-port request.
REQ-013 d_we  in  1  data request is a write when 1.
REQ-014 d_addr  in  ADDR_W  data address.
REQ-015 d_wdata  in  DATA_W  write data.
REQ-016 d_gnt  out  1  data request accepted this cycle.
REQ-017 d_rvalid  out  1  data access complete; read data valid for reads.
REQ-018 d_rdata  out  DATA_W  data-port read data.
REQ-019 mem_en  out  1  memory access strobe.
REQ-020 mem_we  out  1  memory write enable.
REQ-021 mem_addr  out  ADDR_W  memory address.
REQ-022 mem_wdata  out  DATA_W  memory write data.
REQ-023 mem_rdata  in  DATA_W  memory read data, valid exactly 1 cycle after mem_en.

Function
REQ-024 Shares one single-port, 1-cycle-latency, pipelined memory between the fetch and data ports; at most one access is issued per cycle.
REQ-025 Arbitration is combinational in the request cycle: if_gnt/d_gnt, mem_en, mem_we, mem_addr and mem_wdata all reflect the winner in that same cycle.
REQ-026 Only one request: that requester wins.
REQ-027 Both requesting: data wins, unless starve_cnt == STARVE_MAX, in which case fetch wins.
REQ-028 if_gnt and d_gnt are never both 1; mem_en = if_gnt | d_gnt.
REQ-029 mem_we = d_gnt & d_we; mem_wdata = d_wdata when d_gnt, else 0.
REQ-030 starve_cnt (saturating, width ceil(log2(STARVE_MAX+1))) increments when if_req is denied, and clears when if_gnt is asserted or if_req is 0.
REQ-031 On every grant, the winner is registered as owner (IF, D or NONE) together with a pending flag.
REQ-032 Next cycle, owner IF: if_rvalid = 1, if_rdata = mem_rdata.
REQ-033 Next cycle, owner D: d_rvalid = 1, d_rdata = mem_rdata; d_rdata is don't-care for writes but d_rvalid still pulses.
REQ-034 Back-to-back grants are allowed every cycle; a response for cycle N and a grant for cycle N+1 coexist.
REQ-035 rdata ports are 0 whenever the corresponding rvalid is 0.
REQ-036 Requesters hold req/addr/wdata stable until granted; the arbiter does not buffer unaccepted requests.

Reset
REQ-037 While rst = 1: owner = NONE, pending = 0, starve_cnt = 0; all grant and rvalid outputs 0; mem_en = mem_we = 0; all data/address outputs 0.
REQ-038 Reset asserted mid-access drops the pending response; no rvalid pulses in the cycle after reset deasserts.
REQ-039 Arbitration resumes on the first rising edge with rst = 0.

Structure
REQ-040 A shared package cpu_pkg holds ADDR_W/DATA_W defaults, STARVE_MAX and the owner enum (OWN_NONE, OWN_IF, OWN_D).
REQ-041 Single module; no sub-module. Starvation counter and owner register are inline.

Verification
REQ-042 Fetch only: if_req = 1, if_addr = 0x100, mem returns 0xDEADBEEF -> if_gnt = 1 in the same cycle, if_rvalid = 1 with if_rdata = 0xDEADBEEF in the next cycle.
REQ-043 Data write: d_req = 1, d_we = 1, d_addr = 0x40, d_wdata = 0x12345678 -> mem_we = 1, mem_addr = 0x40; d_rvalid pulses one cycle later; if_rvalid stays 0.
REQ-044 Both ports requesting continuously -> grant order D, D, D, IF, D, D, D, IF; starve_cnt returns to 0 after each IF grant.
REQ-045 Alternating IF/D grants every cycle -> rvalid pulses are tagged to the correct port with no bubble, and each rdata matches its address.
REQ-046 rst asserted on the cycle after a grant -> no rvalid pulse follows, and all outputs read 0 during reset.
